// File: rtl/truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper
//
// Purpose:
//   Sequential stimulus/capture stage around a 4-input combinational block.
//   On a start request it drives the vectors 0..15 on {oA,oB,oC,oD}. Each
//   vector is held for SETTLE cycles in DRIVE and then for one SAMPLE cycle,
//   at whose closing edge iY is captured into oTable[idx]. oOnes counts the
//   ones that have been captured. After vector 15 the block enters DONE. It
//   holds the results there until the next start request.
//
// Parameters:
//   SETTLE    cycles each vector is held before sampling (legal 1..15)
//   EXPECTED  golden truth table, used only when TT_COMPARE_EN is defined
//
// Ports:
//   iClk      rising-edge clock
//   iRst_n    synchronous reset, active-low
//   iStart    start request, honoured only in IDLE and DONE
//   iY        output of the combinational stage under sweep
//   oA..oD    current vector, oA = MSB, oD = LSB
//   oBusy     high while in DRIVE or SAMPLE
//   oDone     high in DONE; oTable/oOnes valid
//   oTable    bit n = iY sampled for vector n
//   oOnes     number of ones in oTable (0..16)
//   oMatch    (TT_COMPARE_EN) oTable == EXPECTED, in DONE only
//   oFirstErr (TT_COMPARE_EN) lowest mismatching bit index, 0 on match
//
// Configuration macro: TT_COMPARE_EN adds the golden-table compare outputs.
// ---------------------------------------------------------------------------
module truth_table_sweeper #(
    parameter int unsigned SETTLE   = 1,
    parameter logic [15:0] EXPECTED = 16'hADA7
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iStart,
    input  logic        iY,
    output logic        oA,
    output logic        oB,
    output logic        oC,
    output logic        oD,
    output logic        oBusy,
    output logic        oDone,
    output logic [15:0] oTable,
    output logic [4:0]  oOnes
`ifdef TT_COMPARE_EN
    ,
    output logic        oMatch,
    output logic [3:0]  oFirstErr
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Count value on the last DRIVE cycle of a vector.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_idx;
    logic [3:0]  r_cnt;
    logic [15:0] r_table;
    logic [4:0]  r_ones;
    logic        r_busy;
    logic        r_done;

    logic        w_start_sweep;
    logic        w_sample;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic [15:0] w_table_nxt;
    logic [4:0]  w_ones_nxt;

    // State register.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic of the sweep sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (iStart) begin
                    w_state_nxt = ST_DRIVE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (r_cnt == SETTLE_LAST) begin
                    w_state_nxt = ST_SAMPLE;
                end else begin
                    w_state_nxt = ST_DRIVE;
                end
            end
            ST_SAMPLE: begin
                if (r_idx == 4'd15) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_DRIVE;
                end
            end
            ST_DONE: begin
                if (iStart) begin
                    w_state_nxt = ST_DRIVE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output/datapath decode; the results are registered below.
    always_comb begin
        w_start_sweep = 1'b0;
        w_sample      = 1'b0;
        w_table_nxt   = r_table;
        w_ones_nxt    = r_ones;
        w_busy_nxt    = (w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_SAMPLE);
        w_done_nxt    = (w_state_nxt == ST_DONE);
        // A new sweep starts only from a resting state.
        if (((r_state == ST_IDLE) || (r_state == ST_DONE)) && (w_state_nxt == ST_DRIVE)) begin
            w_start_sweep = 1'b1;
        end else begin
            w_start_sweep = 1'b0;
        end
        if (r_state == ST_SAMPLE) begin
            w_sample           = 1'b1;
            w_table_nxt[r_idx] = iY;
            w_ones_nxt         = r_ones + {4'd0, iY};
        end else begin
            w_sample    = 1'b0;
            w_table_nxt = r_table;
            w_ones_nxt  = r_ones;
        end
    end

    // Vector index, settle counter, captured table and ones count.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_idx   <= 4'd0;
            r_cnt   <= 4'd0;
            r_table <= 16'd0;
            r_ones  <= 5'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            if (w_start_sweep) begin
                r_idx   <= 4'd0;
                r_cnt   <= 4'd0;
                r_table <= 16'd0;
                r_ones  <= 5'd0;
            end else if (w_sample) begin
                r_table <= w_table_nxt;
                r_ones  <= w_ones_nxt;
                r_cnt   <= 4'd0;
                // idx saturates at 15 so the last vector stays on the pins in DONE.
                if (r_idx != 4'd15) begin
                    r_idx <= r_idx + 4'd1;
                end else begin
                    r_idx <= r_idx;
                end
            end else if (r_state == ST_DRIVE) begin
                r_cnt <= r_cnt + 4'd1;
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    assign oA     = r_idx[3];
    assign oB     = r_idx[2];
    assign oC     = r_idx[1];
    assign oD     = r_idx[0];
    assign oBusy  = r_busy;
    assign oDone  = r_done;
    assign oTable = r_table;
    assign oOnes  = r_ones;

`ifdef TT_COMPARE_EN
    logic       r_match;
    logic [3:0] r_first_err;

    // Index of the lowest set bit of a difference vector, 0 when none is set.
    function automatic logic [3:0] lowest_set(input logic [15:0] diff);
        logic [3:0] pos;
        pos = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (diff[i]) begin
                pos = 4'(i);
            end
        end
        return pos;
    endfunction

    // Compare results are evaluated on the table being written on DONE entry.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_match     <= 1'b0;
            r_first_err <= 4'd0;
        end else if (w_state_nxt == ST_DONE) begin
            r_match     <= (w_table_nxt == EXPECTED);
            r_first_err <= lowest_set(w_table_nxt ^ EXPECTED);
        end else begin
            r_match     <= 1'b0;
            r_first_err <= 4'd0;
        end
    end

    assign oMatch    = r_match;
    assign oFirstErr = r_first_err;
`else
    // EXPECTED has no consumer without the compare outputs.
    logic w_unused_expected;
    assign w_unused_expected = ^EXPECTED;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// tb_truth_table_sweeper
//
// Purpose: directed self-checking bench for truth_table_sweeper. dut1 uses
// SETTLE=1 and is fed by a model of the combinational stage whose table is
// 16'hADA7; it can optionally invert vector 4. dut3 uses SETTLE=3 and gets
// a constant iY.
// ---------------------------------------------------------------------------
module tb_truth_table_sweeper;

    logic        clk;
    logic        rst_n;
    logic        start1;
    logic        start3;
    logic        y1;
    logic        y3;
    logic        a1, b1, c1, d1, busy1, done1;
    logic        a3, b3, c3, d3, busy3, done3;
    logic [15:0] tbl1;
    logic [15:0] tbl3;
    logic [4:0]  ones1;
    logic [4:0]  ones3;
    logic [3:0]  vec1;
    logic [3:0]  vec3;
    logic [15:0] gold;
    int          mode;
    int          total;
    int          bad;
`ifdef TT_COMPARE_EN
    logic        match1, match3;
    logic [3:0]  ferr1, ferr3;
`endif

    truth_table_sweeper #(.SETTLE(1), .EXPECTED(16'hADA7)) dut1 (
        .iClk(clk), .iRst_n(rst_n), .iStart(start1), .iY(y1),
        .oA(a1), .oB(b1), .oC(c1), .oD(d1),
        .oBusy(busy1), .oDone(done1), .oTable(tbl1), .oOnes(ones1)
`ifdef TT_COMPARE_EN
        , .oMatch(match1), .oFirstErr(ferr1)
`endif
    );

    truth_table_sweeper #(.SETTLE(3), .EXPECTED(16'hADA7)) dut3 (
        .iClk(clk), .iRst_n(rst_n), .iStart(start3), .iY(y3),
        .oA(a3), .oB(b3), .oC(c3), .oD(d3),
        .oBusy(busy3), .oDone(done3), .oTable(tbl3), .oOnes(ones3)
`ifdef TT_COMPARE_EN
        , .oMatch(match3), .oFirstErr(ferr3)
`endif
    );

    assign vec1 = {a1, b1, c1, d1};
    assign vec3 = {a3, b3, c3, d3};

    // Combinational stage model: mode 1 inverts vector 4 only.
    always_comb begin
        if ((mode == 1) && (vec1 == 4'd4)) begin
            y1 = ~gold[vec1];
        end else begin
            y1 = gold[vec1];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One dut1 sweep with cycle-by-cycle checks; noise pokes iStart while busy.
    task automatic sweep1(input bit noise, input logic [15:0] exp_tbl, input logic [4:0] exp_ones,
                          input bit exp_match, input logic [3:0] exp_ferr);
        int ev;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("clr_table", 32'(tbl1), 32'd0);
        check("clr_ones", 32'(ones1), 32'd0);
        check("start_vec", 32'(vec1), 32'd0);
        check("start_busy", 32'(busy1), 32'd1);
        for (int k = 1; k <= 32; k++) begin
            if (noise && ((k == 5) || (k == 6) || (k == 20))) begin
                start1 = 1'b1;
            end else begin
                start1 = 1'b0;
            end
            tick();
            ev = k / 2;
            if (ev > 15) ev = 15;
            check("vec_order", 32'(vec1), 32'(ev));
            check("busy", 32'(busy1), 32'(k < 32));
            check("done", 32'(done1), 32'(k == 32));
`ifdef TT_COMPARE_EN
            if (k < 32) check("match_idle", 32'(match1), 32'd0);
`endif
        end
        start1 = 1'b0;
        check("table", 32'(tbl1), 32'(exp_tbl));
        check("ones", 32'(ones1), 32'(exp_ones));
`ifdef TT_COMPARE_EN
        check("match", 32'(match1), 32'(exp_match));
        check("first_err", 32'(ferr1), 32'(exp_ferr));
`else
        if (exp_match && (exp_ferr != 4'd0)) check("cmp_args", 32'(exp_ferr), 32'd0);
`endif
    endtask

    // One dut3 sweep with constant iY; oDone must rise 64 cycles after start.
    task automatic sweep3(input logic yv, input logic [15:0] exp_tbl, input logic [4:0] exp_ones);
        y3 = yv;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (k >= 62) check("done3", 32'(done3), 32'(k == 64));
            if (k == 7) check("vec3_hold", 32'(vec3), 32'd1);
            if (k == 8) check("vec3_next", 32'(vec3), 32'd2);
        end
        check("table3", 32'(tbl3), 32'(exp_tbl));
        check("ones3", 32'(ones3), 32'(exp_ones));
        check("busy3", 32'(busy3), 32'd0);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        gold   = 16'hADA7;
        mode   = 0;
        rst_n  = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        y3     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_table", 32'(tbl1), 32'd0);
        check("rst_ones", 32'(ones1), 32'd0);
        check("rst_vec", 32'(vec1), 32'd0);

        // Golden sweep, then a sweep with iStart pokes while busy.
        sweep1(1'b0, 16'hADA7, 5'd10, 1'b1, 4'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("done_hold", 32'(done1), 32'd1);
            check("vec_hold15", 32'(vec1), 32'd15);
        end
        sweep1(1'b1, 16'hADA7, 5'd10, 1'b1, 4'd0);

        // Constant-input sweeps with SETTLE=3.
        sweep3(1'b1, 16'hFFFF, 5'd16);
        sweep3(1'b0, 16'h0000, 5'd0);

        // Reset in the middle of a sweep at idx 7.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 1; k <= 14; k++) tick();
        check("mid_vec7", 32'(vec1), 32'd7);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_busy", 32'(busy1), 32'd0);
        check("mid_rst_table", 32'(tbl1), 32'd0);
        check("mid_rst_ones", 32'(ones1), 32'd0);
        check("mid_rst_vec", 32'(vec1), 32'd0);
        tick();
        check("mid_rst_idle", 32'(busy1), 32'd0);
        check("mid_rst_done", 32'(done1), 32'd0);
        sweep1(1'b0, 16'hADA7, 5'd10, 1'b1, 4'd0);

        // iStart held high: back-to-back sweeps, oDone high for one cycle.
        start1 = 1'b1;
        tick();
        for (int k = 1; k <= 33; k++) begin
            tick();
            if (k >= 31) check("held_done", 32'(done1), 32'(k == 32));
        end
        start1 = 1'b0;
        check("held_clr", 32'(tbl1), 32'd0);
        check("held_busy", 32'(busy1), 32'd1);
        for (int k = 34; k <= 65; k++) begin
            tick();
            if (k >= 64) check("held_done2", 32'(done1), 32'(k == 65));
        end
        check("held_table", 32'(tbl1), 32'hADA7);

        // Stage output inverted for vector 4 only.
        mode = 1;
        sweep1(1'b0, 16'hADB7, 5'd11, 1'b0, 4'd4);
        mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
